// File: rtl/control_multiciclo_if.sv
// Controller <-> IR/PC/datapath/memory bundle: start, opcode, memory handshake, strobes, status.
// master = sequencer side, slave = datapath/memory side.
// Only mem_req/mem_ack handshake; everything else is a per-cycle strobe or level.
interface control_multiciclo_if #(
  parameter int OPCODE_W = 8,
  parameter int CNT_W    = 16
);
  logic                start;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ack;
  logic                mem_req;
  logic                instr_fetch;
  logic                ir_load;
  logic                pc_inc;
  logic                jump_enable;
  logic                write_enable_memory;
  logic                write_enable_reg;
  logic [1:0]          control_op;
  logic [1:0]          alu_op;
  logic                finaliza_execucao;
  logic                illegal_opcode;
  logic                bus_error;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  start, opcode, mem_ack,
    output mem_req, instr_fetch, ir_load, pc_inc, jump_enable, write_enable_memory,
           write_enable_reg, control_op, alu_op, finaliza_execucao, illegal_opcode,
           bus_error, instr_count
  );

  modport slave (
    output start, opcode, mem_ack,
    input  mem_req, instr_fetch, ir_load, pc_inc, jump_enable, write_enable_memory,
           write_enable_reg, control_op, alu_op, finaliza_execucao, illegal_opcode,
           bus_error, instr_count
  );
endinterface

// File: rtl/control_multiciclo.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC | MEM, with HALT and FAULT sinks.
// Latency: 3 cycles per instruction with zero-wait memory, plus 1 per memory wait cycle.
// Backpressure: holds mem_req until mem_ack; gives up into FAULT after MEM_TIMEOUT unacked cycles.
module control_multiciclo #(
  parameter int OPCODE_W      = 8,
  parameter int MEM_TIMEOUT   = 15,
  parameter int TMO_W         = 4,
  parameter int CNT_W         = 16,
  parameter bit STRICT_DECODE = 1'b1
) (
  input logic clk,
  input logic rst,
  control_multiciclo_if.master ctl
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT, FAULT} state_t;

  localparam logic [OPCODE_W-1:0] OP_LI    = OPCODE_W'(8'h00);
  localparam logic [OPCODE_W-1:0] OP_MOV   = OPCODE_W'(8'h01);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(8'h02);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(8'h03);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(8'h05);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(8'h09);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(8'h0A);
  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(8'h0B);
  localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(8'h0C);
  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(8'h0F);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [TMO_W-1:0]    wait_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ill_q, berr_q;
  logic                retire, set_ill, set_berr, tmo_hit;
  logic                mem_req, instr_fetch, ir_load, pc_inc, jump_en, we_mem, we_reg;
  logic [1:0]          control_op, alu_op;

  // The limit is judged on the cycle about to be spent waiting, so an ack in that cycle still wins.
  assign tmo_hit = (wait_q == TMO_W'(MEM_TIMEOUT - 1));

  // State register, opcode capture, wait counter, retire counter and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= ctl.opcode;
      if (state_d != state_q) wait_q <= '0;
      else if (mem_req)       wait_q <= wait_q + TMO_W'(1);
      if (retire && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      if (set_ill)  ill_q  <= 1'b1;
      if (set_berr) berr_q <= 1'b1;
    end
  end

  // Next state and per-cycle datapath strobes; everything idles at zero unless a state asks.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    instr_fetch = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    jump_en     = 1'b0;
    we_mem      = 1'b0;
    we_reg      = 1'b0;
    control_op  = 2'b00;
    alu_op      = 2'b00;
    retire      = 1'b0;
    set_ill     = 1'b0;
    set_berr    = 1'b0;
    case (state_q)
      IDLE: if (ctl.start) state_d = FETCH;
      FETCH: begin
        mem_req     = 1'b1;
        instr_fetch = 1'b1;
        if (ctl.mem_ack) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end else if (tmo_hit) begin
          set_berr = 1'b1;
          state_d  = FAULT;
        end
      end
      DECODE: begin
        case (ctl.opcode)
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_HALT: begin
            retire  = 1'b1;
            state_d = HALT;
          end
          OP_LI, OP_MOV, OP_JMP, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = EXEC;
          default: begin
            if (STRICT_DECODE) begin
              set_ill = 1'b1;
              state_d = FAULT;
            end else begin
              state_d = EXEC;
            end
          end
        endcase
      end
      EXEC: begin
        retire  = 1'b1;
        state_d = FETCH;
        case (op_q)
          OP_LI:  begin we_reg = 1'b1; control_op = 2'b01; pc_inc = 1'b1; end
          OP_MOV: begin we_reg = 1'b1; control_op = 2'b10; pc_inc = 1'b1; end
          OP_JMP: jump_en = 1'b1;
          OP_ADD: begin we_reg = 1'b1; alu_op = 2'b00; pc_inc = 1'b1; end
          OP_SUB: begin we_reg = 1'b1; alu_op = 2'b01; pc_inc = 1'b1; end
          OP_AND: begin we_reg = 1'b1; alu_op = 2'b10; pc_inc = 1'b1; end
          OP_OR:  begin we_reg = 1'b1; alu_op = 2'b11; pc_inc = 1'b1; end
          default: pc_inc = 1'b1;  // tolerated illegal opcode retires as a NOP
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        we_mem  = (op_q == OP_STORE);
        if (ctl.mem_ack) begin
          pc_inc  = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
          if (op_q == OP_LOAD) begin
            we_reg     = 1'b1;
            control_op = 2'b11;
          end
        end else if (tmo_hit) begin
          set_berr = 1'b1;
          state_d  = FAULT;
        end
      end
      HALT, FAULT: state_d = state_q;
      default: state_d = IDLE;
    endcase
  end

  assign ctl.mem_req             = mem_req;
  assign ctl.instr_fetch         = instr_fetch;
  assign ctl.ir_load             = ir_load;
  assign ctl.pc_inc              = pc_inc;
  assign ctl.jump_enable         = jump_en;
  assign ctl.write_enable_memory = we_mem;
  assign ctl.write_enable_reg    = we_reg;
  assign ctl.control_op          = control_op;
  assign ctl.alu_op              = alu_op;
  assign ctl.finaliza_execucao   = (state_q == HALT);
  assign ctl.illegal_opcode      = ill_q;
  assign ctl.bus_error           = berr_q;
  assign ctl.instr_count         = cnt_q;

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
Parametrised multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute and memory phases. It handshakes with instruction/data memory via req/ack and drives the same datapath strobes: reg/mem write enables, control_op mux select, jump, halt. It adds wait-state tolerance, a memory timeout, illegal-opcode trapping and a retired-instruction counter, and sits between the IR/PC and the datapath.

Parameters:
OPCODE_W, 8, opcode width in bits; opcode values occupy the low bits, upper bits must be zero for legal opcodes
MEM_TIMEOUT, 15, max cycles waiting for mem_ack before fault (>=1)
TMO_W, 4, width of the wait counter; must hold MEM_TIMEOUT
CNT_W, 16, width of retired-instruction counter
STRICT_DECODE, 1, 1 = illegal opcode traps to FAULT; 0 = illegal opcode retires as NOP

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching; ignored in any other state
opcode  in  OPCODE_W  opcode field from IR; valid from the cycle after ir_load
mem_ack  in  1  memory completes current request this cycle
mem_req  out  1  memory request (fetch or data)
instr_fetch  out  1  1 = current request is an instruction fetch (address mux = PC)
ir_load  out  1  load IR with memory read data
pc_inc  out  1  PC <= PC+1
jump_enable  out  1  PC <= jump target
write_enable_memory  out  1  data store write strobe
write_enable_reg  out  1  register file write strobe
control_op  out  2  reg write source: 00 ALU, 01 sign-extend, 10 reg2, 11 memory
alu_op  out  2  00 add, 01 sub, 10 and, 11 or
finaliza_execucao  out  1  halted; level, held
illegal_opcode  out  1  sticky illegal-opcode flag
bus_error  out  1  sticky memory-timeout flag
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT, FAULT.
- Reset (rst=0, async): state=IDLE. All outputs 0, counters 0. Reset mid-instruction aborts with no strobe.
- IDLE: start=1 -> FETCH.
- FETCH: mem_req=1, instr_fetch=1. On mem_ack, ir_load=1 in the same cycle (combinational on ack) -> DECODE. Zero-wait ack (ack in first FETCH cycle) is legal.
- DECODE: opcode registered internally. Next state:
  - 0x02 LOAD / 0x03 STORE -> MEM
  - 0x0F -> HALT
  - 0x00, 0x01, 0x05, 0x09-0x0C -> EXEC
  - otherwise illegal
- EXEC (1 cycle), then -> FETCH:
  - 0x00: write_enable_reg=1, control_op=01, pc_inc=1
  - 0x01: write_enable_reg=1, control_op=10, pc_inc=1
  - 0x05: jump_enable=1, pc_inc=0
  - 0x09/0A/0B/0C: write_enable_reg=1, control_op=00, alu_op=00/01/10/11 respectively, pc_inc=1
- MEM: mem_req=1, instr_fetch=0. STORE holds write_enable_memory=1 for every MEM cycle. On mem_ack: pc_inc=1 -> FETCH; for LOAD, write_enable_reg=1 and control_op=11 in the ack cycle only.
- Illegal opcode:
  - STRICT_DECODE=1: illegal_opcode<=1, -> FAULT.
  - STRICT_DECODE=0: EXEC with pc_inc only (NOP), counted as retired.
- Timeout: wait counter clears on entry to FETCH/MEM and increments each cycle without ack. If it reaches MEM_TIMEOUT with no ack: bus_error<=1, -> FAULT, no strobe. Ack in the same cycle the limit is hit wins.
- HALT: finaliza_execucao=1 from the cycle HALT is entered; exit only by reset. HALT counts as retired.
- FAULT: all strobes 0, sticky flags held; exit only by reset.
- instr_count increments once per retired instruction (EXEC exit, MEM ack, HALT entry); saturates at all-ones.
- Outside the listed cases every strobe is 0; alu_op=00, control_op=00 default.
- Latency with zero-wait memory: ALU/LI/MOV/JUMP take 3 cycles; LOAD/STORE take 3 cycles; each memory wait cycle adds 1.

Test Plan:
- Reset then start, ack every cycle, opcodes 0x09 then 0x0F -> write_enable_reg+alu_op=00 in cycle 3; finaliza_execucao=1 from cycle 6; instr_count=2.
- LOAD with mem_ack delayed 4 cycles in MEM -> mem_req held 5 cycles; write_enable_reg=1 and control_op=11 only in the ack cycle; pc_inc pulses once.
- STORE with zero-wait ack -> write_enable_memory=1 for exactly 1 cycle; write_enable_reg stays 0.
- opcode 0x07 -> STRICT_DECODE=1: illegal_opcode=1, FAULT, no further mem_req. STRICT_DECODE=0: one pc_inc, instr_count+1, next FETCH.
- FETCH with no ack, MEM_TIMEOUT=15 -> bus_error=1 after 15 cycles, strobes 0. Repeat with ack on cycle 15 -> no fault.
- rst asserted mid-MEM of a STORE -> all outputs 0 immediately (async); start ignored until IDLE; instr_count=0.
